// File: rtl/aes_pkg.sv
// Shared AES definitions: block and byte widths, the SubBytes FSM state
// type, and the forward/inverse S-box tables with a lookup helper.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Forward S-box, entry x at bits [2047-8x -: 8] (entry 0x00 is the top byte).
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, same layout as SBOX_FWD.
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Table lookup; entry x sits at the top-down byte offset x.
  function automatic logic [AES_BYTE_W-1:0] sbox_lookup(
    input logic [AES_BYTE_W-1:0] x,
    input logic                  inv
  );
    logic [10:0] top;
    top = 11'd2047 - {x, 3'b000};
    return inv ? SBOX_INV[top -: 8] : SBOX_FWD[top -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational S-box lane with forward/inverse select.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] data,
  input  logic                  inv,
  output logic [AES_BYTE_W-1:0] result
);

  // Pure table lookup; no state in the lane.
  always_comb begin
    result = sbox_lookup(data, inv);
  end

endmodule

// File: rtl/sub_bytes_serial.sv
// Serial AES SubBytes: accepts a 128-bit state, substitutes BYTES_PER_CYCLE
// bytes per cycle through shared S-box lanes, then returns the state.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid are registered, so neither depends
// combinationally on in_valid or out_ready; once out_valid is high the
// output is held until it is taken.
module sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
);

  localparam int STEPS = AES_BLOCK_W / (AES_BYTE_W * BYTES_PER_CYCLE);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     mode;
  logic [0:AES_BLOCK_W-1]   work;
  logic [0:AES_BLOCK_W-1]   work_next;
  int                       base;
  logic [AES_BYTE_W-1:0]    lane_in  [BYTES_PER_CYCLE];
  logic [AES_BYTE_W-1:0]    lane_out [BYTES_PER_CYCLE];

  // Select the group of bytes addressed by cnt and feed them to the lanes.
  always_comb begin
    base = (STEPS > 1) ? int'(cnt) * BYTES_PER_CYCLE : 0;
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      lane_in[g] = work[AES_BYTE_W*(base+g) +: AES_BYTE_W];
    end
  end

  // Shared S-box lanes, all using the mode latched with the block.
  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    aes_sbox u_sbox (
      .data   (lane_in[g]),
      .inv    (mode),
      .result (lane_out[g])
    );
  end

  // Merge the substituted bytes back into a copy of the working register.
  always_comb begin
    work_next = work;
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      work_next[AES_BYTE_W*(base+g) +: AES_BYTE_W] = lane_out[g];
    end
  end

  // Control FSM with registered handshake outputs and the working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            mode     <= in_inv;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          work <= work_next;
          if (cnt == CNT_LAST) begin
            // Last group: cnt is left as is so it never wraps mid-block.
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // No bypass: the next block is accepted one cycle after hand-off.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign out_data = work;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Bench for sub_bytes_serial with three instances (N = 1, 4, 16).
// Expected blocks come from an arithmetic GF(2^8) S-box model.
module tb_sub_bytes_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         in_inv    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [0:127] in_data   [3];
  logic [0:127] out_data  [3];

  int steps_tab [3] = '{16, 4, 1};

  sub_bytes_serial #(.BYTES_PER_CYCLE(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]));
  sub_bytes_serial #(.BYTES_PER_CYCLE(4)) dut_n4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]));
  sub_bytes_serial #(.BYTES_PER_CYCLE(16)) dut_n16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]));

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];

  localparam logic [127:0] INC_BLK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] INC_FWD = 128'h637c777bf26b6fc53001672bfed7ab76;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] x);
    logic [7:0] g;
    g = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (x != 8'h00 && gmul(x, 8'(c)) == 8'h01) g = 8'(c);
    end
    return g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      fwd_tab[x] = model_sbox(8'(x));
      inv_tab[fwd_tab[x]] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = d[127-8*i -: 8];
      r[127-8*i -: 8] = inv ? inv_tab[b] : fwd_tab[b];
    end
    return r;
  endfunction

  // ---------------- driver: one full block with latency checks ----------------
  task automatic run_block(input int sel, input logic [127:0] data, input logic inv,
                           input string name, output logic [127:0] got);
    logic [127:0] exp;
    exp_q.push_back(sub_model(data, inv));
    @(negedge clk);
    in_data[sel] = data; in_inv[sel] = inv; in_valid[sel] = 1'b1; out_ready[sel] = 1'b0;
    n_tests++;
    if (in_ready[sel] !== 1'b1) begin
      n_fail++; $display("FAIL %s_accept_ready: in_ready=%b expected 1", name, in_ready[sel]);
    end
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the block must ignore them.
    in_valid[sel] = 1'b0; in_data[sel] = ~data; in_inv[sel] = ~inv;
    repeat (steps_tab[sel] - 1) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid[sel] !== 1'b0) begin
      n_fail++; $display("FAIL %s_early_valid: out_valid=%b expected 0", name, out_valid[sel]);
    end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid[sel] !== 1'b1) begin
      n_fail++; $display("FAIL %s_latency: out_valid=%b expected 1", name, out_valid[sel]);
    end
    got = out_data[sel];
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL %s_data: got %h expected %h", name, got, exp);
    end
    @(negedge clk);
    out_ready[sel] = 1'b1;
    n_tests++;
    if (in_ready[sel] !== 1'b0) begin
      n_fail++; $display("FAIL %s_no_bypass: in_ready=%b expected 0", name, in_ready[sel]);
    end
    @(posedge clk); #1;
    out_ready[sel] = 1'b0;
    n_tests++;
    if (out_valid[sel] !== 1'b0 || in_ready[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_handoff: out_valid=%b in_ready=%b expected 0 1", name, out_valid[sel], in_ready[sel]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if (in_ready[s] !== 1'b1 || out_valid[s] !== 1'b0 || out_data[s] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_state_%0d: in_ready=%b out_valid=%b out_data=%h expected 1 0 0",
                 s, in_ready[s], out_valid[s], out_data[s]);
      end
    end
  endtask

  task automatic test_zero();
    logic [127:0] got;
    run_block(0, 128'h0, 1'b0, "zero_n1", got);
    n_tests++;
    if (got !== {16{8'h63}}) begin
      n_fail++; $display("FAIL zero_const: got %h expected %h", got, {16{8'h63}});
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] got, back;
    for (int s = 0; s < 3; s++) begin
      run_block(s, INC_BLK, 1'b0, $sformatf("fwd_s%0d", s), got);
      n_tests++;
      if (got !== INC_FWD) begin
        n_fail++; $display("FAIL fwd_const_s%0d: got %h expected %h", s, got, INC_FWD);
      end
      run_block(s, got, 1'b1, $sformatf("inv_s%0d", s), back);
      n_tests++;
      if (back !== INC_BLK) begin
        n_fail++; $display("FAIL inv_const_s%0d: got %h expected %h", s, back, INC_BLK);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] got, d;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 3; k++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        run_block(s, d, 1'($urandom_range(0, 1)), $sformatf("rand_s%0d_%0d", s, k), got);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp, held;
    int guard;
    exp = sub_model(INC_BLK, 1'b0);
    exp_q.push_back(exp);
    @(negedge clk);
    in_data[1] = INC_BLK; in_inv[1] = 1'b0; in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    guard = 0;
    @(negedge clk);
    while (out_valid[1] !== 1'b1 && guard < 50) begin
      @(negedge clk); guard++;
    end
    exp = exp_q.pop_front();
    n_tests++;
    if (guard >= 50 || out_data[1] !== exp) begin
      n_fail++; $display("FAIL bp_first: got %h expected %h (wait %0d)", out_data[1], exp, guard);
    end
    held = exp;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid[1] = 1'b1; in_data[1] = {4{32'hdeadbeef}};
      end
      if (i == 4) in_valid[1] = 1'b0;
      n_tests++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== held || in_ready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b out_data=%h expected 1 0 %h",
                 i, out_valid[1], in_ready[1], out_data[1], held);
      end
      @(negedge clk);
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    n_tests++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1 0", in_ready[1], out_valid[1]);
    end
    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pulse_ignored: out_valid=%b in_ready=%b expected 0 1", out_valid[1], in_ready[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got;
    @(negedge clk);
    in_data[0] = {16{8'haa}}; in_inv[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_busy: in_ready=%b expected 0", in_ready[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 128'h0 || in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b out_data=%h expected 0 1 0",
               out_valid[0], in_ready[0], out_data[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_block(0, {16{8'hff}}, 1'b0, "after_reset", got);
    n_tests++;
    if (got !== {16{8'h16}}) begin
      n_fail++; $display("FAIL after_reset_const: got %h expected %h", got, {16{8'h16}});
    end
  endtask

  task automatic test_back_to_back();
    int acc [4];
    for (int s = 0; s < 3; s++) begin
      exp_q.delete();
      out_ready[s] = 1'b1;
      fork
        begin : driver
          logic [127:0] d;
          int g;
          for (int b = 0; b < 4; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(sub_model(d, 1'(b)));
            @(negedge clk);
            in_valid[s] = 1'b1; in_data[s] = d; in_inv[s] = 1'(b);
            g = 0;
            while (in_ready[s] !== 1'b1 && g < 200) begin
              @(negedge clk); g++;
            end
            @(posedge clk); #1;
            acc[b] = cycle;
            in_valid[s] = 1'b0;
          end
        end
        begin : monitor
          logic [127:0] exp;
          int g;
          for (int b = 0; b < 4; b++) begin
            g = 0;
            @(negedge clk);
            while (out_valid[s] !== 1'b1 && g < 200) begin
              @(negedge clk); g++;
            end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            n_tests++;
            if (g >= 200 || out_data[s] !== exp) begin
              n_fail++;
              $display("FAIL b2b_s%0d_blk%0d: got %h expected %h (wait %0d)", s, b, out_data[s], exp, g);
            end
          end
        end
      join
      for (int b = 1; b < 4; b++) begin
        n_tests++;
        if (acc[b] - acc[b-1] !== steps_tab[s] + 2) begin
          n_fail++;
          $display("FAIL b2b_s%0d_rate%0d: interval %0d expected %0d", s, b, acc[b] - acc[b-1], steps_tab[s] + 2);
        end
      end
      @(negedge clk);
      out_ready[s] = 1'b0;
      repeat (2) @(posedge clk);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    for (int s = 0; s < 3; s++) begin
      in_valid[s] = 1'b0; in_inv[s] = 1'b0; out_ready[s] = 1'b0; in_data[s] = '0;
    end
    rst_n = 1'b0;
    build_tables();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_zero();
    test_round_trip();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sub_bytes_serial.md
# sub_bytes_serial

Sequential SubBytes stage of the AES round datapath, sitting directly upstream of the ShiftRows permutation. It accepts a 128-bit state over a valid/ready handshake and substitutes its 16 bytes through a small number of shared S-box instances, N bytes per cycle. It returns the substituted state over a second valid/ready handshake. Forward or inverse substitution is selected per block, so one instance serves both encrypt and decrypt rounds.

## Interface
- BYTES_PER_CYCLE, 1, number of S-box lanes N; legal values 1, 2, 4, 8, 16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream offers a state
- in_ready  output  1  block can accept a state
- in_data  input  [0:127]  input state; byte i = in_data[8*i +: 8], column-major (byte 4c+r = row r, column c)
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with in_data
- out_valid  output  1  substituted state available
- out_ready  input  1  downstream accepts the state
- out_data  output  [0:127]  substituted state, same byte ordering as in_data

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch in_data into the working register and in_inv into the mode register, clear the lane counter cnt, go to BUSY.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each cycle, replace working bytes cnt*N … cnt*N+N-1 with S(byte), or S⁻¹(byte) when mode = 1. Then increment cnt.
  - When cnt = 16/N − 1, this is the last update; go to DONE.
  - cnt width is clog2(16/N), minimum 1 bit. It never wraps inside a block.
- DONE:
  - out_valid = 1, out_data = working register.
  - The working register is held stable while out_valid = 1 and out_ready = 0.
  - On out_ready: go to IDLE. in_ready stays 0 in this cycle; there is no bypass from DONE to accept.
- out_data is the working register in every state. Its value is only meaningful in DONE.
- in_inv and in_data changes outside the accepting cycle are ignored.
- Reset values: in_ready = 1 (IDLE), out_valid = 0, out_data = 0, cnt = 0, mode = 0.
- Reset asserted mid-block (BUSY or DONE) discards the block. Outputs take their reset values immediately.

## Timing
- Input accepted at rising edge k (in_valid & in_ready).
- out_valid is high from edge k + 16/N onward: 16 cycles for N = 1, 1 cycle for N = 16.
- Output transferred at the first edge with out_valid & out_ready. in_ready rises one cycle later.
- Maximum throughput is one block per 16/N + 2 cycles.
- The S-box is purely combinational. The critical path is working register → S-box → working register.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- Shared package aes_pkg holds:
  - AES_BLOCK_W = 128 and AES_BYTE_W = 8
  - the state enum {IDLE, BUSY, DONE}
  - the forward and inverse S-box constant tables
- Sub-module aes_sbox: 8-bit in, inv select, 8-bit out, combinational lookup. Instantiated N times via generate.

## Test plan
- All-zero state, in_inv = 0, N = 1: out_valid at edge k+16; out_data = 16 bytes of 63.
- in_data bytes 00,01,…,0F, in_inv = 0: out_data = 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76.
- Round trip: feed the previous output back with in_inv = 1; out_data = 00,01,…,0F. Repeat both directions for N = 4 (latency 4) and N = 16 (latency 1).
- Backpressure: hold out_ready = 0 for 10 cycles in DONE.
  - out_valid stays 1, out_data stays stable, in_ready stays 0.
  - A new in_valid pulse in this window is not accepted.
  - After out_ready, in_ready = 1 exactly one cycle later.
- Reset mid-block: assert rst_n = 0 at cnt = 7 in BUSY.
  - out_valid = 0, out_data = 0 and in_ready = 1 immediately, without waiting for a clock edge.
  - A following block of all-FF returns 16 bytes of 16.
- Back-to-back blocks with out_ready tied high: inputs accepted every 16/N + 2 cycles; outputs arrive in order with correct values.
